ibex_cheri_wb_buffer: RTL and testbench
=======================================

# ibex_cheri_wb_buffer

Two-entry writeback buffer directly downstream of the execution block. It captures the integer result, the CHERI capability result and both CHERI exception vectors each time EX signals a valid result. It presents them in order to the register-file write port, with a valid/ready handshake. It suppresses register writes for faulting instructions and reports the highest-priority CHERI exception to the controller.

## Interface
Parameters:
- CheriCapWidth, 91, width of a capability register value.
- CheriExcWidth, ibex_pkg::CheriExcWidth, width of each exception vector; must be ≤ 32.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  synchronous active-high reset.
- ex_valid_i  input  1  EX result valid this cycle.
- ex_ready_o  output  1  buffer can accept an entry; a push occurs when ex_valid_i && ex_ready_o.
- result_ex_i  input  32  integer result.
- cheri_result_i  input  CheriCapWidth  capability result.
- cheri_wrote_capability_i  input  1  entry writes a capability, not an integer.
- cheri_exceptions_a_i  input  CheriExcWidth  exceptions raised on operand a.
- cheri_exceptions_b_i  input  CheriExcWidth  exceptions raised on operand b.
- rf_we_i  input  1  instruction writes a destination register.
- rf_waddr_i  input  5  destination register index.
- flush_i  input  1  discard all buffered entries.
- wb_valid_o  output  1  head entry is valid.
- wb_ready_i  input  1  write port accepts the head; a pop occurs when wb_valid_o && wb_ready_i.
- rf_we_o  output  1  register write enable for the head.
- rf_waddr_o  output  5  head destination index.
- rf_wdata_o  output  CheriCapWidth  head write data.
- rf_wcap_o  output  1  head write data is a capability.
- exc_valid_o  output  1  head carries an exception; qualified by a pop.
- exc_operand_o  output  1  faulting operand: 0 = a, 1 = b.
- exc_cause_o  output  5  index of the lowest set bit of the selected exception vector.

## Operation
Storage:
- 2-entry circular FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2).

Entry capture on push:
- Data:
  - If cheri_wrote_capability_i is 1: wdata = cheri_result_i and wcap = 1.
  - Otherwise: wdata = {(CheriCapWidth-32) zeros, result_ex_i} and wcap = 0. The tag bit is therefore always cleared for integer results.
- Exception selection:
  - If cheri_exceptions_a_i is nonzero: exc = 1, operand = 0, vector = cheri_exceptions_a_i.
  - Else if cheri_exceptions_b_i is nonzero: exc = 1, operand = 1, vector = cheri_exceptions_b_i.
  - Else exc = 0.
- Cause: the lowest-set-bit index of the selected vector, computed at push time and stored. Cause is 0 when exc = 0.
- Write enable: stored we = rf_we_i && !exc && (rf_waddr_i != 0).
- All pushed instructions, including non-writing ones, occupy an entry so that exceptions stay in order.

Head outputs:
- Taken from the entry at the read pointer.
- rf_we_o = wb_valid_o && entry.we.
- exc_valid_o = wb_valid_o && entry.exc.

Exception retire (pop of an entry with exc = 1):
- Acts as a self-flush: count becomes 0, both pointers become 0, and a push in the same cycle is dropped.

Flush:
- flush_i has priority over push and pop: count and pointers go to 0, and nothing is written.

Ready:
- ex_ready_o = !rst_i && (count != 2). It is registered-state-derived and does not depend on wb_ready_i.

## Timing
Reset:
- While rst_i is high and on the first cycle after it, count = 0.
- All outputs are 0 (ex_ready_o = 0 during reset, 1 on the first cycle after).
- Stored payloads are don't-care, but are reset to 0 for verification determinism.

Latency:
- A push in cycle N gives wb_valid_o = 1 in cycle N+1. There is no combinational EX→RF bypass.

Count update per edge:
- Push only: +1.
- Pop only: −1.
- Push and pop together: unchanged. This is legal at count = 1; at count = 2 ex_ready_o is 0, so no push occurs.

Boundaries:
- Empty pop: impossible, because wb_valid_o = 0.
- Full: ex_ready_o = 0; ex_valid_i is ignored.
- Pointers wrap modulo 2.

Handshake:
- Head outputs stay stable while wb_valid_o && !wb_ready_i.
- EX must hold its inputs while ex_ready_o = 0.

Simultaneous events, in priority order: rst_i > flush_i > exception-retire self-flush > normal push/pop.

## Test plan
1. **Basic integer write:** reset, push integer result 0xDEADBEEF to x5 with wb_ready_i = 1.
   - Next cycle: rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0x0_..._DEADBEEF, rf_wcap_o = 0; buffer is empty one cycle later.
2. **Backpressure and ordering:** hold wb_ready_i = 0 and push 3 results (x1 = 1, x2 = 2, x3 = 3).
   - ex_ready_o falls after the second push; the third is held by EX.
   - Releasing wb_ready_i retires 1, 2, 3 in order on consecutive cycles.
3. **Capability write and x0:** push a capability with cheri_wrote_capability_i = 1 to x7 → rf_wdata_o = cheri_result_i, rf_wcap_o = 1. Push to x0 with rf_we_i = 1 → rf_we_o = 0.
4. **Exception priority:** push with cheri_exceptions_a_i = 0b0100 and cheri_exceptions_b_i = 0b0001.
   - Response: exc_valid_o = 1, exc_operand_o = 0, exc_cause_o = 2, rf_we_o = 0.
   - A younger buffered entry is discarded on retire (count → 0).
5. **Flush with simultaneous activity:** with 2 entries buffered, assert flush_i together with wb_ready_i and ex_valid_i.
   - Next cycle: wb_valid_o = 0, count = 0, no register write.
6. **Reset mid-operation:** assert rst_i with 1 entry pending.
   - Next cycle all outputs are 0; the first cycle after deassertion has ex_ready_o = 1 and wb_valid_o = 0.

Source files
------------

// File: rtl/ibex_cheri_wb_buffer.sv
// Two-entry in-order writeback buffer between EX and the register-file write port.
// Captures integer/capability results plus CHERI exception state; a faulting head self-flushes on retire.
module ibex_cheri_wb_buffer #(
  parameter int CheriCapWidth = 91,
  parameter int CheriExcWidth = 11
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [31:0]              result_ex_i,
  input  logic [CheriCapWidth-1:0] cheri_result_i,
  input  logic                     cheri_wrote_capability_i,
  input  logic [CheriExcWidth-1:0] cheri_exceptions_a_i,
  input  logic [CheriExcWidth-1:0] cheri_exceptions_b_i,
  input  logic                     rf_we_i,
  input  logic [4:0]               rf_waddr_i,
  input  logic                     flush_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [CheriCapWidth-1:0] rf_wdata_o,
  output logic                     rf_wcap_o,
  output logic                     exc_valid_o,
  output logic                     exc_operand_o,
  output logic [4:0]               exc_cause_o
);

  typedef struct packed {
    logic [CheriCapWidth-1:0] wdata;
    logic                     wcap;
    logic                     we;
    logic [4:0]               waddr;
    logic                     exc;
    logic                     operand;
    logic [4:0]               cause;
  } entry_t;

  entry_t     mem_q [2];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] count_q;

  entry_t     new_entry;
  entry_t     head;
  logic       push;
  logic       pop;

  // Scanning from the top down leaves the index of the lowest set bit.
  function automatic logic [4:0] lowest_set(input logic [CheriExcWidth-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = CheriExcWidth - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // NOTE: every field gets a default first so no path through this block infers a latch.
  always_comb begin
    new_entry = '0;
    if (cheri_wrote_capability_i) begin
      new_entry.wdata = cheri_result_i;
      new_entry.wcap  = 1'b1;
    end else begin
      new_entry.wdata = {{(CheriCapWidth-32){1'b0}}, result_ex_i};
      new_entry.wcap  = 1'b0;
    end
    if (|cheri_exceptions_a_i) begin
      new_entry.exc     = 1'b1;
      new_entry.operand = 1'b0;
      new_entry.cause   = lowest_set(cheri_exceptions_a_i);
    end else if (|cheri_exceptions_b_i) begin
      new_entry.exc     = 1'b1;
      new_entry.operand = 1'b1;
      new_entry.cause   = lowest_set(cheri_exceptions_b_i);
    end
    new_entry.waddr = rf_waddr_i;
    new_entry.we    = rf_we_i && !new_entry.exc && (rf_waddr_i != 5'd0);
  end

  assign head       = mem_q[rptr_q];
  assign ex_ready_o = !rst_i && (count_q != 2'd2);
  assign wb_valid_o = !rst_i && (count_q != 2'd0);
  assign push       = ex_valid_i && ex_ready_o;
  assign pop        = wb_valid_o && wb_ready_i;

  // Head fields are forced to zero whenever nothing is presented, including during reset.
  assign rf_we_o       = wb_valid_o && head.we;
  assign rf_waddr_o    = wb_valid_o ? head.waddr : 5'd0;
  assign rf_wdata_o    = wb_valid_o ? head.wdata : '0;
  assign rf_wcap_o     = wb_valid_o && head.wcap;
  assign exc_valid_o   = wb_valid_o && head.exc;
  assign exc_operand_o = wb_valid_o && head.operand;
  assign exc_cause_o   = wb_valid_o ? head.cause : 5'd0;

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      // NOTE: payloads need no reset functionally; clearing them keeps simulation deterministic.
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (flush_i || (pop && head.exc)) begin
      // A retiring fault discards younger entries and any push in the same cycle.
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= new_entry;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_cheri_wb_buffer.sv
// Self-checking bench for ibex_cheri_wb_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ibex_cheri_wb_buffer;

  localparam int CapW = 91;
  localparam int ExcW = 11;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            ex_valid_i;
  logic            ex_ready_o;
  logic [31:0]     result_ex_i;
  logic [CapW-1:0] cheri_result_i;
  logic            cheri_wrote_capability_i;
  logic [ExcW-1:0] cheri_exceptions_a_i;
  logic [ExcW-1:0] cheri_exceptions_b_i;
  logic            rf_we_i;
  logic [4:0]      rf_waddr_i;
  logic            flush_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [CapW-1:0] rf_wdata_o;
  logic            rf_wcap_o;
  logic            exc_valid_o;
  logic            exc_operand_o;
  logic [4:0]      exc_cause_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            we;
    logic [4:0]      waddr;
    logic [CapW-1:0] wdata;
    logic            wcap;
    logic            exc;
    logic            operand;
    logic [4:0]      cause;
  } exp_t;

  exp_t model_q[$];

  always #5 clk_i = ~clk_i;

  ibex_cheri_wb_buffer #(.CheriCapWidth(CapW), .CheriExcWidth(ExcW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .result_ex_i(result_ex_i), .cheri_result_i(cheri_result_i),
    .cheri_wrote_capability_i(cheri_wrote_capability_i),
    .cheri_exceptions_a_i(cheri_exceptions_a_i), .cheri_exceptions_b_i(cheri_exceptions_b_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .flush_i(flush_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_wcap_o(rf_wcap_o),
    .exc_valid_o(exc_valid_o), .exc_operand_o(exc_operand_o), .exc_cause_o(exc_cause_o)
  );

  task automatic idle_inputs();
    ex_valid_i = 0; result_ex_i = '0; cheri_result_i = '0; cheri_wrote_capability_i = 0;
    cheri_exceptions_a_i = '0; cheri_exceptions_b_i = '0; rf_we_i = 0; rf_waddr_i = '0;
    flush_i = 0; wb_ready_i = 0;
  endtask

  task automatic drive_int(input logic [4:0] addr, input logic [31:0] val);
    ex_valid_i = 1; cheri_wrote_capability_i = 0; result_ex_i = val; rf_we_i = 1;
    rf_waddr_i = addr; cheri_exceptions_a_i = '0; cheri_exceptions_b_i = '0;
  endtask

  // Expected entry derived directly from the capture rules.
  function automatic exp_t expect_entry();
    exp_t e;
    logic [ExcW-1:0] v;
    e.wcap  = cheri_wrote_capability_i;
    e.wdata = cheri_wrote_capability_i ? cheri_result_i : CapW'(result_ex_i);
    e.exc = (cheri_exceptions_a_i != 0) || (cheri_exceptions_b_i != 0);
    e.operand = (cheri_exceptions_a_i == 0) && (cheri_exceptions_b_i != 0);
    v = e.operand ? cheri_exceptions_b_i : cheri_exceptions_a_i;
    e.cause = 0;
    if (e.exc) while (v[e.cause] == 1'b0) e.cause++;
    e.waddr = rf_waddr_i;
    e.we = rf_we_i && !e.exc && (rf_waddr_i != 0);
    return e;
  endfunction

  task automatic test_reset();
    logic [CapW+17:0] all_out;
    rst_i = 1; idle_inputs();
    @(negedge clk_i); @(negedge clk_i);
    all_out = {ex_ready_o, wb_valid_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_wcap_o,
               exc_valid_o, exc_operand_o, exc_cause_o};
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_out); end
    rst_i = 0;
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_exit_ready got %b exp 1", ex_ready_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_exit_valid got %b exp 0", wb_valid_o); end
  endtask

  task automatic test_int_write();
    idle_inputs(); wb_ready_i = 1;
    drive_int(5'd5, 32'hDEADBEEF);
    @(negedge clk_i);
    ex_valid_i = 0;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL int_valid got %b exp 1", wb_valid_o); end
    checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL int_we got %b exp 1", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd5) begin errors++; $display("FAIL int_waddr got %0d exp 5", rf_waddr_o); end
    checks++; if (rf_wdata_o !== CapW'(32'hDEADBEEF)) begin errors++; $display("FAIL int_wdata got %h exp deadbeef", rf_wdata_o); end
    checks++; if (rf_wcap_o !== 1'b0) begin errors++; $display("FAIL int_wcap got %b exp 0", rf_wcap_o); end
    @(negedge clk_i);
    checks++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin errors++; $display("FAIL int_empty got v%b r%b exp v0 r1", wb_valid_o, ex_ready_o); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    drive_int(5'd1, 32'd1);
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", ex_ready_o); end
    drive_int(5'd2, 32'd2);
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", ex_ready_o); end
    drive_int(5'd3, 32'd3);
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold got %b exp 0", ex_ready_o); end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (wb_valid_o !== 1'b1 || rf_waddr_o !== 5'(k) || rf_wdata_o !== CapW'(k) || rf_we_o !== 1'b1) begin
        errors++; $display("FAIL bp_order%0d got v%b a%0d d%0h exp v1 a%0d d%0h", k, wb_valid_o, rf_waddr_o, rf_wdata_o, k, k);
      end
      wb_ready_i = 1;
      if (k == 3) ex_valid_i = 0;
      @(negedge clk_i);
    end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", wb_valid_o); end
  endtask

  task automatic test_cap_x0();
    logic [CapW-1:0] cap;
    idle_inputs(); wb_ready_i = 1;
    cap = {$urandom, $urandom, $urandom};
    cap[CapW-1] = 1'b1;
    ex_valid_i = 1; cheri_wrote_capability_i = 1; cheri_result_i = cap; rf_we_i = 1; rf_waddr_i = 5'd7;
    @(negedge clk_i);
    checks++; if (rf_wdata_o !== cap || rf_wcap_o !== 1'b1 || rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7) begin
      errors++; $display("FAIL cap_write got d%h c%b we%b a%0d exp d%h c1 we1 a7", rf_wdata_o, rf_wcap_o, rf_we_o, rf_waddr_o, cap);
    end
    drive_int(5'd0, 32'h1234);
    @(negedge clk_i);
    ex_valid_i = 0;
    checks++; if (wb_valid_o !== 1'b1 || rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_we got v%b we%b exp v1 we0", wb_valid_o, rf_we_o); end
    @(negedge clk_i);
  endtask

  task automatic test_exc_priority();
    idle_inputs();
    drive_int(5'd9, 32'h55);
    cheri_exceptions_a_i = ExcW'(4'b0100); cheri_exceptions_b_i = ExcW'(4'b0001);
    @(negedge clk_i);
    drive_int(5'd10, 32'h66);
    @(negedge clk_i);
    ex_valid_i = 0;
    checks++; if (exc_valid_o !== 1'b1 || exc_operand_o !== 1'b0 || exc_cause_o !== 5'd2 || rf_we_o !== 1'b0) begin
      errors++; $display("FAIL exc_head got e%b o%b c%0d we%b exp e1 o0 c2 we0", exc_valid_o, exc_operand_o, exc_cause_o, rf_we_o);
    end
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL exc_full got %b exp 0", ex_ready_o); end
    wb_ready_i = 1;
    @(negedge clk_i);
    checks++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin errors++; $display("FAIL exc_selfflush got v%b r%b exp v0 r1", wb_valid_o, ex_ready_o); end
  endtask

  task automatic test_flush();
    idle_inputs();
    drive_int(5'd4, 32'h4);
    @(negedge clk_i);
    drive_int(5'd6, 32'h6);
    @(negedge clk_i);
    flush_i = 1; wb_ready_i = 1; drive_int(5'd8, 32'h8);
    @(negedge clk_i);
    idle_inputs();
    checks++; if (wb_valid_o !== 1'b0 || rf_we_o !== 1'b0 || ex_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_full got v%b we%b r%b exp v0 we0 r1", wb_valid_o, rf_we_o, ex_ready_o);
    end
    // At count 1 the push would be accepted without the flush.
    drive_int(5'd11, 32'hB);
    @(negedge clk_i);
    flush_i = 1; wb_ready_i = 1; drive_int(5'd12, 32'hC);
    @(negedge clk_i);
    idle_inputs();
    checks++; if (wb_valid_o !== 1'b0 || rf_we_o !== 1'b0) begin errors++; $display("FAIL flush_one got v%b we%b exp v0 we0", wb_valid_o, rf_we_o); end
  endtask

  task automatic test_reset_mid();
    logic [CapW+17:0] all_out;
    idle_inputs();
    drive_int(5'd13, 32'hD);
    @(negedge clk_i);
    ex_valid_i = 0;
    rst_i = 1;
    @(negedge clk_i);
    all_out = {ex_ready_o, wb_valid_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_wcap_o,
               exc_valid_o, exc_operand_o, exc_cause_o};
    checks++; if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs got %h exp 0", all_out); end
    rst_i = 0;
    @(negedge clk_i);
    checks++; if (ex_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_exit got r%b v%b exp r1 v0", ex_ready_o, wb_valid_o); end
  endtask

  task automatic test_random();
    exp_t e;
    bit   push, pop;
    idle_inputs();
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (wb_valid_o !== (model_q.size() != 0) || ex_ready_o !== (model_q.size() != 2)) begin
        errors++; $display("FAIL rnd_state cyc%0d got v%b r%b exp occupancy %0d", cyc, wb_valid_o, ex_ready_o, model_q.size());
      end
      if (model_q.size() != 0) begin
        e = model_q[0];
        checks++;
        if (rf_we_o !== e.we || rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata || rf_wcap_o !== e.wcap ||
            exc_valid_o !== e.exc || exc_operand_o !== e.operand || exc_cause_o !== e.cause) begin
          errors++;
          $display("FAIL rnd_head cyc%0d got we%b a%0d d%h c%b e%b o%b k%0d exp we%b a%0d d%h c%b e%b o%b k%0d", cyc,
                   rf_we_o, rf_waddr_o, rf_wdata_o, rf_wcap_o, exc_valid_o, exc_operand_o, exc_cause_o,
                   e.we, e.waddr, e.wdata, e.wcap, e.exc, e.operand, e.cause);
        end
      end
      // EX keeps an un-accepted request stable.
      if (!(ex_valid_i && model_q.size() == 2)) begin
        ex_valid_i = ($urandom_range(0, 3) != 0);
        result_ex_i = $urandom;
        cheri_result_i = {$urandom, $urandom, $urandom};
        cheri_wrote_capability_i = $urandom_range(0, 1);
        rf_we_i = ($urandom_range(0, 4) != 0);
        rf_waddr_i = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        cheri_exceptions_a_i = ($urandom_range(0, 7) == 0) ? ExcW'($urandom) : '0;
        cheri_exceptions_b_i = ($urandom_range(0, 7) == 0) ? ExcW'($urandom) : '0;
      end
      wb_ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 24) == 0);
      push = ex_valid_i && (model_q.size() < 2);
      pop  = wb_ready_i && (model_q.size() > 0);
      e = expect_entry();
      if (flush_i) model_q.delete();
      else if (pop && model_q[0].exc) model_q.delete();
      else begin
        if (pop) void'(model_q.pop_front());
        if (push) model_q.push_back(e);
      end
      @(negedge clk_i);
    end
    idle_inputs();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_int_write();
    test_back_to_back();
    test_cap_x0();
    test_exc_priority();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
